// File: rtl/router_pkg.sv
// Shared types and helpers for the 1x3 router: read-side FSM states,
// header field extraction, and default sizing constants.
package router_pkg;

  localparam int FIFO_DEPTH       = 16;
  localparam int SOFT_RST_TIMEOUT = 30;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_IN_PKT = 1'b1
  } rd_state_t;

  // Header byte layout: payload length in [7:2], destination address in [1:0].
  function automatic logic [5:0] hdr_length(input logic [7:0] hdr);
    return hdr[7:2];
  endfunction

  function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[1:0];
  endfunction

endpackage

// File: rtl/router_fifo_timer.sv
// Stall watchdog for one destination FIFO: counts cycles where data waits
// unread and fires a flush request plus a registered soft_reset pulse.
module router_fifo_timer #(
  parameter int TIMEOUT = 30
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_valid,
  input  logic i_read_enb,
  output logic o_flush,
  output logic o_soft_reset
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;
  logic          r_soft_reset;
  logic          w_stall;

  assign w_stall      = i_valid && !i_read_enb;
  // Flush fires on the edge that would complete the TIMEOUT-th stalled cycle.
  assign o_flush      = w_stall && (r_count == LAST);
  assign o_soft_reset = r_soft_reset;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count      <= '0;
      r_soft_reset <= 1'b0;
    end else if (o_flush) begin
      r_count      <= '0;
      r_soft_reset <= 1'b1;
    end else begin
      r_soft_reset <= 1'b0;
      r_count      <= w_stall ? r_count + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/router_dst_fifo.sv
// Per-destination output FIFO of the 1x3 router: stores bytes with a header
// flag, tracks packet boundaries on the read side, and self-flushes on stall.
module router_dst_fifo
  import router_pkg::*;
#(
  parameter int DEPTH   = FIFO_DEPTH,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = SOFT_RST_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_enb,
  input  logic [DATA_W-1:0] data_in,
  input  logic              lfd_state,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              soft_reset,
  output logic              packet_done,
  output logic              proto_err
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W:0]   r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_data_out;
  rd_state_t         r_state;
  logic [6:0]        r_remaining;
  logic              r_packet_done;
  logic              r_proto_err;

  logic              w_empty;
  logic              w_full;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_flush;
  logic [DATA_W:0]   w_rd_entry;
  logic              w_rd_hdr;
  logic [6:0]        w_len_load;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_ok    = write_enb && !w_full;
  assign w_rd_ok    = read_enb && !w_empty;
  assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
  assign w_rd_hdr   = w_rd_entry[DATA_W];
  // Header length counts payload bytes; the trailing parity byte adds one.
  assign w_len_load = {1'b0, hdr_length(w_rd_entry[7:0])} + 7'd1;

  router_fifo_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_valid      (!w_empty),
    .i_read_enb   (read_enb),
    .o_flush      (w_flush),
    .o_soft_reset (soft_reset)
  );

  always_ff @(posedge clock) begin
    if (!reset && !w_flush && w_wr_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clock) begin
    if (reset || w_flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_data_out    <= '0;
      r_state       <= RD_IDLE;
      r_remaining   <= '0;
      r_packet_done <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_packet_done <= 1'b0;
      r_proto_err   <= 1'b0;
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= w_rd_entry[DATA_W-1:0];
        case (r_state)
          RD_IDLE: begin
            if (w_rd_hdr) begin
              r_remaining <= w_len_load;
              r_state     <= RD_IN_PKT;
            end
          end
          RD_IN_PKT: begin
            // A header arriving mid-packet restarts the count from the new header.
            if (w_rd_hdr) begin
              r_proto_err <= 1'b1;
              r_remaining <= w_len_load;
            end else if (r_remaining == 7'd1) begin
              r_packet_done <= 1'b1;
              r_remaining   <= '0;
              r_state       <= RD_IDLE;
            end else begin
              r_remaining <= r_remaining - 7'd1;
            end
          end
          default: r_state <= RD_IDLE;
        endcase
      end
    end
  end

  assign data_out    = r_data_out;
  assign valid_out   = !w_empty;
  assign empty       = w_empty;
  assign full        = w_full;
  assign packet_done = r_packet_done;
  assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_router_dst_fifo.sv
// Self-checking bench for router_dst_fifo: directed scenarios plus random
// traffic, compared against a queue-based packet/timeout reference model.
module tb_router_dst_fifo;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 30;
  localparam logic [13:0] RESET_VEC = {8'h00, 1'b0, 1'b0, 1'b1, 3'b000};

  logic       clock;
  logic       reset;
  logic       write_enb;
  logic [7:0] data_in;
  logic       lfd_state;
  logic       read_enb;
  logic [7:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       soft_reset;
  logic       packet_done;
  logic       proto_err;

  int n_checks;
  int n_pass;

  // Reference model state: stored entries as {header_flag, byte}.
  logic [8:0] q[$];
  logic [7:0] m_data;
  logic       m_in_pkt;
  int         m_left;
  int         m_stall;
  logic       m_soft;
  logic       m_pd;
  logic       m_pe;

  router_dst_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (8),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .write_enb  (write_enb),
    .data_in    (data_in),
    .lfd_state  (lfd_state),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .full       (full),
    .empty      (empty),
    .soft_reset (soft_reset),
    .packet_done(packet_done),
    .proto_err  (proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [13:0] obs();
    return {data_out, valid_out, full, empty, soft_reset, packet_done, proto_err};
  endfunction

  function automatic logic [13:0] exp_vec();
    return {m_data, (q.size() != 0), (q.size() == DEPTH), (q.size() == 0), m_soft, m_pd, m_pe};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample #1 after.
  task automatic tick(input logic we, input logic [7:0] d, input logic lfd,
                      input logic re, input logic rst);
    logic       stalled;
    logic       can_wr;
    logic [8:0] e;
    write_enb = we;
    data_in   = d;
    lfd_state = lfd;
    read_enb  = re;
    reset     = rst;
    if (rst) begin
      q.delete();
      m_data = 8'h00; m_in_pkt = 1'b0; m_left = 0; m_stall = 0;
      m_soft = 1'b0; m_pd = 1'b0; m_pe = 1'b0;
    end else begin
      stalled = (q.size() != 0) && !re;
      m_soft = 1'b0; m_pd = 1'b0; m_pe = 1'b0;
      if (stalled && m_stall == TIMEOUT - 1) begin
        q.delete();
        m_data = 8'h00; m_in_pkt = 1'b0; m_left = 0; m_stall = 0;
        m_soft = 1'b1;
      end else begin
        can_wr = we && (q.size() < DEPTH);
        if (re && q.size() != 0) begin
          e = q.pop_front();
          m_data = e[7:0];
          if (e[8]) begin
            if (m_in_pkt) m_pe = 1'b1;
            m_left   = int'(e[7:2]) + 1;
            m_in_pkt = 1'b1;
          end else if (m_in_pkt) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
              m_pd     = 1'b1;
              m_in_pkt = 1'b0;
            end
          end
        end
        if (can_wr) q.push_back({lfd, d});
        m_stall = stalled ? m_stall + 1 : 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs() !== RESET_VEC) $display("[TB] FAIL reset_values: got %h expected %h", obs(), RESET_VEC);
    else n_pass++;
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs() !== exp_vec()) $display("[TB] FAIL reset_release: got %h expected %h", obs(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_packet();
    logic [7:0] bytes [5];
    bytes[0] = 8'h0D; bytes[1] = 8'hA1; bytes[2] = 8'hA2; bytes[3] = 8'hA3; bytes[4] = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, bytes[i], (i == 0), 1'b0, 1'b0);
      n_checks++;
      if (obs() !== exp_vec()) $display("[TB] FAIL pkt_write%0d: got %h expected %h", i, obs(), exp_vec());
      else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (data_out !== bytes[i] || packet_done !== (i == 4))
        $display("[TB] FAIL pkt_read%0d: got data %h done %b expected data %h done %b",
                 i, data_out, packet_done, bytes[i], (i == 4));
      else n_pass++;
      n_checks++;
      if (obs() !== exp_vec()) $display("[TB] FAIL pkt_read_model%0d: got %h expected %h", i, obs(), exp_vec());
      else n_pass++;
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (empty !== 1'b1 || data_out !== 8'h0F)
      $display("[TB] FAIL pkt_drained: got empty %b data %h expected empty 1 data 0f", empty, data_out);
    else n_pass++;
  endtask

  task automatic test_full();
    logic [7:0] saved [16];
    logic [7:0] d;
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      if (i < 16) saved[i] = d;
      tick(1'b1, d, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== exp_vec()) $display("[TB] FAIL full_write%0d: got %h expected %h", i, obs(), exp_vec());
      else n_pass++;
      if (i >= 15) begin
        n_checks++;
        if (full !== 1'b1) $display("[TB] FAIL full_flag%0d: got %b expected 1", i, full);
        else n_pass++;
      end
    end
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (data_out !== saved[i] || empty !== (i == 15))
        $display("[TB] FAIL full_read%0d: got data %h empty %b expected data %h empty %b",
                 i, data_out, empty, saved[i], (i == 15));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (full !== 1'b0 || empty !== 1'b0 || obs() !== exp_vec())
        $display("[TB] FAIL simul%0d: got %h expected %h", i, obs(), exp_vec());
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== exp_vec()) $display("[TB] FAIL simul_drain%0d: got %h expected %h", i, obs(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (empty !== 1'b1) $display("[TB] FAIL simul_empty: got %b expected 1", empty);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int k_seen;
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(i + 8'h51), 1'b0, 1'b0, 1'b0);
    k_seen = -1;
    for (int k = 1; k <= 40; k++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== exp_vec()) $display("[TB] FAIL timeout_cyc%0d: got %h expected %h", k, obs(), exp_vec());
      else n_pass++;
      if (soft_reset === 1'b1 && k_seen < 0) begin
        k_seen = k;
        n_checks++;
        if (empty !== 1'b1 || data_out !== 8'h00 || valid_out !== 1'b0)
          $display("[TB] FAIL timeout_flush_state: got empty %b valid %b data %h expected 1 0 00",
                   empty, valid_out, data_out);
        else n_pass++;
      end
    end
    n_checks++;
    if (k_seen !== 28) $display("[TB] FAIL timeout_cycle: got %0d expected 28", k_seen);
    else n_pass++;

    for (int i = 0; i < 3; i++) tick(1'b1, 8'(i + 8'h61), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 26; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    k_seen = -1;
    for (int k = 1; k <= 40; k++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== exp_vec()) $display("[TB] FAIL restart_cyc%0d: got %h expected %h", k, obs(), exp_vec());
      else n_pass++;
      if (soft_reset === 1'b1 && k_seen < 0) k_seen = k;
    end
    n_checks++;
    if (k_seen !== 30) $display("[TB] FAIL timeout_restart: got %0d expected 30", k_seen);
    else n_pass++;
  endtask

  task automatic test_proto_err();
    logic [7:0] bytes [5];
    logic [4:0] hdrs;
    bytes[0] = 8'h09; bytes[1] = 8'hAA; bytes[2] = 8'h04; bytes[3] = 8'hB1; bytes[4] = 8'hB2;
    hdrs = 5'b00101;
    for (int i = 0; i < 5; i++) tick(1'b1, bytes[i], hdrs[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (proto_err !== (i == 2) || packet_done !== (i == 4))
        $display("[TB] FAIL proto_read%0d: got err %b done %b expected err %b done %b",
                 i, proto_err, packet_done, (i == 2), (i == 4));
      else n_pass++;
      n_checks++;
      if (obs() !== exp_vec()) $display("[TB] FAIL proto_model%0d: got %h expected %h", i, obs(), exp_vec());
      else n_pass++;
    end
    tick(1'b1, 8'h0D, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (obs() !== RESET_VEC) $display("[TB] FAIL midpkt_reset: got %h expected %h", obs(), RESET_VEC);
    else n_pass++;
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== 8'h00 || empty !== 1'b1)
      $display("[TB] FAIL read_after_reset: got data %h empty %b expected 00 1", data_out, empty);
    else n_pass++;
    // The next header must start a fresh packet, not continue the discarded one.
    tick(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (packet_done !== 1'b1 || data_out !== 8'h5A)
      $display("[TB] FAIL zero_len_pkt: got done %b data %h expected 1 5a", packet_done, data_out);
    else n_pass++;
  endtask

  task automatic test_random();
    logic re;
    for (int c = 0; c < 600; c++) begin
      if ((c / 60) % 3 == 2) re = 1'b0;
      else re = 1'($urandom_range(0, 1));
      tick(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 4) == 0),
           re, ($urandom_range(0, 199) == 0));
      n_checks++;
      if (obs() !== exp_vec()) $display("[TB] FAIL random_cyc%0d: got %h expected %h", c, obs(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    write_enb = 1'b0;
    data_in   = 8'h00;
    lfd_state = 1'b0;
    read_enb  = 1'b0;
    test_reset();
    test_packet();
    test_full();
    test_back_to_back();
    test_timeout();
    test_proto_err();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
